// File: rtl/subtrator_pkg.sv
// Shared definitions for the digit-serial subtractor: FSM state type and
// elaboration helpers for the step count and digit-index width.
package subtrator_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int steps(input int width, input int digit);
        return (digit < 1) ? 1 : width / digit;
    endfunction

    // A single-step operation still needs a 1-bit index register.
    function automatic int index_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/subtrator_digito.sv
// Combinational DIGIT-bit subtractor cell: {bout, d} = a - b - bin.
module subtrator_digito #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout
);

    logic [DIGIT:0] full;

    always_comb begin
        full = {1'b0, a} - {1'b0, b} - {{DIGIT{1'b0}}, bin};
    end

    assign d    = full[DIGIT-1:0];
    assign bout = full[DIGIT];

endmodule

// File: rtl/subtrator_serial.sv
// Multi-cycle subtractor: d = a - b - borrow_in, DIGIT bits per clock, LSB
// digit first, with the inter-digit borrow carried in a register.
module subtrator_serial
    import subtrator_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int STEPS = steps(WIDTH, DIGIT);
    localparam int KW    = index_width(STEPS);
    localparam logic [KW-1:0] LAST_K = KW'(STEPS - 1);

    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_check
        $error("subtrator_serial: WIDTH must be a positive multiple of DIGIT");
    end

    state_t           state;
    logic [WIDTH-1:0] a_lat;
    logic [WIDTH-1:0] b_lat;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic [KW-1:0]    k;
    logic             brw;
    logic [31:0]      base;
    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT-1:0] diff;
    logic             bo;

    // res_next already holds the current digit so the final edge can publish
    // the complete result without an extra cycle.
    always_comb begin
        base     = 32'(k) * 32'(DIGIT);
        a_dig    = a_lat[base +: DIGIT];
        b_dig    = b_lat[base +: DIGIT];
        res_next = res;
        res_next[base +: DIGIT] = diff;
    end

    subtrator_digito #(
        .DIGIT(DIGIT)
    ) u_digito (
        .a   (a_dig),
        .b   (b_dig),
        .bin (brw),
        .d   (diff),
        .bout(bo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            d          <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
            a_lat      <= '0;
            b_lat      <= '0;
            res        <= '0;
            k          <= '0;
            brw        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_lat <= a;
                        b_lat <= b;
                        brw   <= borrow_in;
                        res   <= '0;
                        k     <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    res <= res_next;
                    brw <= bo;
                    k   <= k + 1'b1;
                    if (k == LAST_K) begin
                        d          <= res_next;
                        borrow_out <= bo;
                        overflow   <= (a_lat[WIDTH-1] != b_lat[WIDTH-1]) &&
                                      (res_next[WIDTH-1] != a_lat[WIDTH-1]);
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_subtrator_serial.sv
// Bench for subtrator_serial: directed checks on a 16/4 instance plus random
// sweeps over several WIDTH/DIGIT combinations against an arithmetic model.
module tb_subtrator_serial;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        borrow_in;
    logic        busy;
    logic        done;
    logic [15:0] d;
    logic        borrow_out;
    logic        overflow;

    int n_tests = 0;
    int n_fail  = 0;
    int sweeps_finished = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    subtrator_serial #(
        .WIDTH(16),
        .DIGIT(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .borrow_in (borrow_in),
        .busy      (busy),
        .done      (done),
        .d         (d),
        .borrow_out(borrow_out),
        .overflow  (overflow)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Random sweeps: one instance per WIDTH/DIGIT pair, each with its own stimulus.
    for (genvar gi = 0; gi < 5; gi++) begin : g_sweep
        localparam int W = (gi == 4) ? 8 : 16;
        localparam int D = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 4 : (gi == 3) ? 16 : 8;
        localparam int S = W / D;

        logic         s_rst;
        logic         s_start;
        logic [W-1:0] s_a;
        logic [W-1:0] s_b;
        logic         s_bin;
        logic         s_busy;
        logic         s_done;
        logic [W-1:0] s_d;
        logic         s_bo;
        logic         s_ov;

        subtrator_serial #(
            .WIDTH(W),
            .DIGIT(D)
        ) u_dut (
            .clk       (clk),
            .rst       (s_rst),
            .start     (s_start),
            .a         (s_a),
            .b         (s_b),
            .borrow_in (s_bin),
            .busy      (s_busy),
            .done      (s_done),
            .d         (s_d),
            .borrow_out(s_bo),
            .overflow  (s_ov)
        );

        initial begin
            longint mask;
            longint half;
            longint la;
            longint lb;
            longint lbin;
            longint sa;
            longint sb;
            longint sdiff;
            longint exp_d;
            logic   exp_bo;
            logic   exp_ov;
            int     cnt;

            mask    = (longint'(1) << W) - 1;
            half    = longint'(1) << (W - 1);
            s_rst   = 1'b1;
            s_start = 1'b0;
            s_a     = '0;
            s_b     = '0;
            s_bin   = 1'b0;
            repeat (2) @(negedge clk);
            s_rst = 1'b0;
            @(negedge clk);
            for (int n = 0; n < 1000; n++) begin
                la   = longint'($urandom) & mask;
                lb   = longint'($urandom) & mask;
                lbin = longint'($urandom_range(0, 1));
                if (n % 16 == 0) la = half;
                if (n % 16 == 1) lb = mask;
                exp_d  = (la - lb - lbin) & mask;
                exp_bo = (la < lb + lbin);
                sa     = (la >= half) ? la - 2 * half : la;
                sb     = (lb >= half) ? lb - 2 * half : lb;
                sdiff  = sa - sb - lbin;
                exp_ov = (sdiff < -half) || (sdiff > half - 1);

                s_start = 1'b1;
                s_a     = W'(la);
                s_b     = W'(lb);
                s_bin   = lbin[0];
                @(negedge clk);
                s_start = 1'b0;
                s_a     = W'($urandom);
                s_b     = W'($urandom);
                s_bin   = 1'($urandom);
                cnt = 0;
                while (!s_done && cnt < S + 3) begin
                    @(negedge clk);
                    cnt++;
                end
                check_eq($sformatf("sw%0d_lat", gi), 32'(cnt), 32'(S));
                check_eq($sformatf("sw%0d_d", gi), 32'(s_d), 32'(exp_d));
                check_eq($sformatf("sw%0d_bo", gi), 32'(s_bo), 32'(exp_bo));
                check_eq($sformatf("sw%0d_ov", gi), 32'(s_ov), 32'(exp_ov));
            end
            sweeps_finished++;
        end
    end

    task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic bi);
        start     = 1'b1;
        a         = av;
        b         = bv;
        borrow_in = bi;
        @(negedge clk);
        start     = 1'b0;
        a         = 16'($urandom);
        b         = 16'($urandom);
        borrow_in = 1'($urandom);
    endtask

    task automatic wait_done(output int lat, output int busy_cycles);
        lat = 0;
        busy_cycles = 0;
        while (!done && lat < 12) begin
            if (busy) busy_cycles++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic op_check(input string tag, input logic [15:0] av, input logic [15:0] bv,
                            input logic bi, input logic [15:0] ed, input logic ebo, input logic eov);
        int lat;
        int bc;
        start_op(av, bv, bi);
        wait_done(lat, bc);
        check_eq({tag, "_lat"}, 32'(lat), 32'd4);
        check_eq({tag, "_busy"}, 32'(bc), 32'd4);
        check_eq({tag, "_d"}, 32'(d), 32'(ed));
        check_eq({tag, "_bo"}, 32'(borrow_out), 32'(ebo));
        check_eq({tag, "_ov"}, 32'(overflow), 32'(eov));
        @(negedge clk);
        check_eq({tag, "_pulse"}, 32'(done), 32'd0);
        check_eq({tag, "_hold"}, 32'(d), 32'(ed));
    endtask

    initial begin
        int lat;
        int bc;
        int dones;
        logic [15:0] d_seen;

        rst       = 1'b1;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        borrow_in = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_d", 32'(d), 32'd0);
        check_eq("rst_bo", 32'(borrow_out), 32'd0);
        check_eq("rst_ov", 32'(overflow), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        op_check("v1", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
        op_check("v2", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        op_check("v3", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        op_check("v4", 16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0);

        // start re-asserted while busy, with operands changing mid-operation
        start_op(16'h00F0, 16'h000F, 1'b0);
        start = 1'b1;
        a     = 16'hAAAA;
        b     = 16'h5555;
        repeat (2) @(negedge clk);
        start = 1'b0;
        dones = 0;
        d_seen = '0;
        for (int i = 0; i < 10; i++) begin
            if (done) begin
                dones++;
                d_seen = d;
            end
            @(negedge clk);
        end
        check_eq("ign_dones", 32'(dones), 32'd1);
        check_eq("ign_d", 32'(d_seen), 32'h00E1);

        // back-to-back: second start issued in the done cycle
        start_op(16'h1234, 16'h0234, 1'b0);
        wait_done(lat, bc);
        check_eq("b2b_lat1", 32'(lat), 32'd4);
        check_eq("b2b_d1", 32'(d), 32'h1000);
        start_op(16'h0100, 16'h0001, 1'b1);
        wait_done(lat, bc);
        check_eq("b2b_lat2", 32'(lat), 32'd4);
        check_eq("b2b_d2", 32'(d), 32'h00FE);
        @(negedge clk);

        op_check("v5", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);

        // reset during the second RUN cycle
        start_op(16'h4444, 16'h1111, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("mrst_busy", 32'(busy), 32'd0);
        check_eq("mrst_done", 32'(done), 32'd0);
        check_eq("mrst_d", 32'(d), 32'd0);
        check_eq("mrst_bo", 32'(borrow_out), 32'd0);
        check_eq("mrst_ov", 32'(overflow), 32'd0);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        check_eq("mrst_nodone", 32'(dones), 32'd0);
        op_check("post_rst", 16'h4444, 16'h1111, 1'b0, 16'h3333, 1'b0, 1'b0);

        for (int i = 0; i < 40000 && sweeps_finished < 5; i++) @(negedge clk);
        check_eq("sweeps_finished", 32'(sweeps_finished), 32'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
